decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 215 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ARM instruction decode stage: decodes each accepted word on entry and
// queues the decoded fields/flags in a DEPTH-entry FIFO for the consumer.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/instruction;
//   out_valid/out_ready; opcode, ra, rb, rc, rotate_imm, immediate, shift,
//   shift_imm, branch_off; shifter_en, rotator_en, registerFile_en, sel;
//   is_mem, is_load, is_branch, is_link, undef; count.
// Option: DECODE_COND_EN adds a 4-bit cond output; cond=1111 decodes undef.
module decode_stage #(
  parameter int REG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               opcode,
  output logic [REG_W-1:0]         ra,
  output logic [REG_W-1:0]         rb,
  output logic [REG_W-1:0]         rc,
  output logic [3:0]               rotate_imm,
  output logic [7:0]               immediate,
  output logic [1:0]               shift,
  output logic [4:0]               shift_imm,
  output logic                     shifter_en,
  output logic                     rotator_en,
  output logic                     registerFile_en,
  output logic                     sel,
  output logic                     is_mem,
  output logic                     is_load,
  output logic                     is_branch,
  output logic                     is_link,
  output logic                     undef,
  output logic [23:0]              branch_off,
`ifdef DECODE_COND_EN
  output logic [3:0]               cond,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
`ifdef DECODE_COND_EN
    logic [3:0]       cond;
`endif
    logic [3:0]       opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [3:0]       rotate_imm;
    logic [7:0]       immediate;
    logic [1:0]       shift;
    logic [4:0]       shift_imm;
    logic [23:0]      branch_off;
    logic             shifter_en;
    logic             rotator_en;
    logic             rf_en;
    logic             sel;
    logic             is_mem;
    logic             is_load;
    logic             is_branch;
    logic             is_link;
    logic             undef;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] w);
    entry_t e;
    e            = '0;
    e.opcode     = w[24:21];
    e.ra         = REG_W'(w[19:16]);
    e.rc         = REG_W'(w[15:12]);
    e.rb         = REG_W'(w[3:0]);
    e.rotate_imm = w[11:8];
    e.immediate  = w[7:0];
    e.shift      = w[6:5];
    e.shift_imm  = w[11:7];
    e.branch_off = w[23:0];
    unique case (w[27:25])
      3'b000: begin
        e.shifter_en = 1'b1;
        e.sel        = 1'b1;
        e.rf_en      = 1'b1;
      end
      3'b001: begin
        e.rotator_en = 1'b1;
        e.rf_en      = 1'b1;
      end
      3'b010: begin
        e.is_mem  = 1'b1;
        e.is_load = w[20];
        e.rf_en   = w[20];
      end
      3'b011: begin
        if (!w[4]) begin
          e.is_mem     = 1'b1;
          e.shifter_en = 1'b1;
          e.sel        = 1'b1;
          e.is_load    = w[20];
          e.rf_en      = w[20];
        end else begin
          e.undef = 1'b1;
        end
      end
      3'b101: begin
        e.is_branch = 1'b1;
        e.is_link   = w[24];
        e.rf_en     = w[24];
      end
      default: e.undef = 1'b1;
    endcase
`ifdef DECODE_COND_EN
    e.cond = w[31:28];
    // "never" condition: treat as undefined, no datapath activity
    if (w[31:28] == 4'hF) begin
      e.shifter_en = 1'b0;
      e.rotator_en = 1'b0;
      e.rf_en      = 1'b0;
      e.sel        = 1'b0;
      e.is_mem     = 1'b0;
      e.is_load    = 1'b0;
      e.is_branch  = 1'b0;
      e.is_link    = 1'b0;
      e.undef      = 1'b1;
    end
`endif
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  entry_t          head;

  assign in_ready  = (count_q < FULL) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = decode(instruction);
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign count      = count_q;
  assign opcode     = head.opcode;
  assign ra         = head.ra;
  assign rb         = head.rb;
  assign rc         = head.rc;
  assign rotate_imm = head.rotate_imm;
  assign immediate  = head.immediate;
  assign shift      = head.shift;
  assign shift_imm  = head.shift_imm;
  assign branch_off = head.branch_off;
`ifdef DECODE_COND_EN
  assign cond       = head.cond;
`endif

  // stale entries stay in storage; flags are masked so an empty queue
  // never advertises datapath activity
  assign shifter_en      = out_valid & head.shifter_en;
  assign rotator_en      = out_valid & head.rotator_en;
  assign registerFile_en = out_valid & head.rf_en;
  assign sel             = out_valid & head.sel;
  assign is_mem          = out_valid & head.is_mem;
  assign is_load         = out_valid & head.is_load;
  assign is_branch       = out_valid & head.is_branch;
  assign is_link         = out_valid & head.is_link;
  assign undef           = out_valid & head.undef;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage (default DEPTH=2, REG_W=4).
// Hand-computed expectations for decode fields, FIFO and reset behaviour.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [3:0]  rotate_imm;
  logic [7:0]  immediate;
  logic [1:0]  shift;
  logic [4:0]  shift_imm;
  logic        shifter_en, rotator_en, registerFile_en, sel;
  logic        is_mem, is_load, is_branch, is_link, undef;
  logic [23:0] branch_off;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction    (instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .opcode         (opcode),
    .ra             (ra),
    .rb             (rb),
    .rc             (rc),
    .rotate_imm     (rotate_imm),
    .immediate      (immediate),
    .shift          (shift),
    .shift_imm      (shift_imm),
    .shifter_en     (shifter_en),
    .rotator_en     (rotator_en),
    .registerFile_en(registerFile_en),
    .sel            (sel),
    .is_mem         (is_mem),
    .is_load        (is_load),
    .is_branch      (is_branch),
    .is_link        (is_link),
    .undef          (undef),
    .branch_off     (branch_off),
    .count          (count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // one clock edge with the given controls, then settle 1ns past it
  task automatic step(input logic iv, input logic [31:0] w,
                      input logic ordy, input logic fl);
    in_valid    = iv;
    instruction = w;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    instruction = '0;
    #2;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_opcode", opcode, 0);
    check("rst_flags", {shifter_en, rotator_en, registerFile_en, sel,
                        is_mem, is_load, is_branch, is_link, undef}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // data-processing register form
    step(1'b1, 32'hE0821003, 1'b0, 1'b0);
    check("dp_valid", out_valid, 1);
    check("dp_count", count, 1);
    check("dp_opcode", opcode, 4'b0100);
    check("dp_regs", {ra, rc, rb}, 12'h213);
    check("dp_en", {shifter_en, rotator_en, sel, registerFile_en}, 4'b1011);
    check("dp_undef", undef, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pop_empty", {out_valid, count}, 0);
    check("empty_flags", shifter_en, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("underflow", count, 0);

    // immediate form
    step(1'b1, 32'hE3A010FF, 1'b0, 1'b0);
    check("imm_en", {shifter_en, rotator_en, sel, registerFile_en}, 4'b0101);
    check("imm_fields", {opcode, rc, immediate}, 16'hD1FF);

    // simultaneous push+pop at count=1
    step(1'b1, 32'hE5912004, 1'b1, 1'b0);
    check("pp_count", count, 1);
    check("ld_flags", {is_mem, is_load, registerFile_en, is_branch}, 4'b1110);
    check("ld_rotimm", rotate_imm, 0);
    step(1'b1, 32'hEB000010, 1'b0, 1'b0);
    check("full_cnt", {count, in_ready}, 3'b100);
    check("head_kept", is_load, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bl_flags", {is_branch, is_link, registerFile_en, is_mem}, 4'b1110);
    check("bl_off", branch_off, 24'h000010);
    step(1'b0, '0, 1'b1, 1'b0);

    // fill, reject extra, drain in order
    step(1'b1, 32'hE3A010FF, 1'b0, 1'b0);
    step(1'b1, 32'hE3A01055, 1'b0, 1'b0);
    step(1'b1, 32'hE3A01077, 1'b0, 1'b0);
    check("full_hold", count, 2);
    check("full_rdy", in_ready, 0);
    // pop while full with push offered: push ignored
    step(1'b1, 32'hE3A01077, 1'b1, 1'b0);
    check("full_pop", count, 1);
    check("order_2nd", immediate, 8'h55);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drained", {out_valid, count}, 0);

    // load/store register offset form and its undefined variant
    step(1'b1, 32'hE7912004, 1'b0, 1'b0);
    check("ldr_reg", {is_mem, shifter_en, sel, is_load, registerFile_en,
                      undef}, 6'b111110);
    check("ldr_shift", {shift, shift_imm}, 7'b0000000);
    step(1'b1, 32'hE7912014, 1'b1, 1'b0);
    check("ldr_undef", {undef, is_mem, shifter_en, registerFile_en}, 4'b1000);

    // flush with two queued and in_valid high
    step(1'b1, 32'hE0821003, 1'b0, 1'b0);
    check("pre_flush", count, 2);
    step(1'b1, 32'hE0821003, 1'b1, 1'b1);
    check("flush", {out_valid, count}, 0);
    step(1'b1, 32'hEE000000, 1'b0, 1'b0);
    check("fmt111", {undef, shifter_en, rotator_en, registerFile_en, sel,
                     is_mem, is_branch}, 7'b1000000);

    // async reset with one entry queued
    check("pre_rst", count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {out_valid, count, undef}, 0);
    #10;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
